// File: rtl/m3ds_apb_slave_mux_sec.sv
// APB3 slave-side decoder and response multiplexer for the m3ds peripheral subsystem.
// Splits one APB region into NUM_SLV equal slots, enforces per-slot secure-only access,
// answers blocked or unmapped accesses with a local error, and aborts hung slaves.
module m3ds_apb_slave_mux_sec #(
    parameter int unsigned NUM_SLV        = 4,
    parameter int unsigned SLV_ADDR_WIDTH = 12,
    parameter logic [15:0] SEC_MASK       = 16'h0000,
    parameter int unsigned TIMEOUT        = 256
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   psel_i,
    input  logic [31:0]            paddr_i,
    input  logic                   penable_i,
    input  logic                   pprot_i,
    input  logic [32*NUM_SLV-1:0]  prdata_s_i,
    input  logic [NUM_SLV-1:0]     pready_s_i,
    input  logic [NUM_SLV-1:0]     pslverr_s_i,
    output logic [NUM_SLV-1:0]     psel_o,
    output logic                   penable_o,
    output logic [31:0]            prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic                   timeout_o,
    input  logic                   timeout_clr_i
);

    typedef enum logic [1:0] {StIdle, StFwd, StErr} state_e;

    localparam logic [4:0]  NumSlvW   = 5'(NUM_SLV);
    localparam logic [15:0] TimeoutW  = 16'(TIMEOUT);
    localparam logic        TimeoutEn = (TIMEOUT != 0);

    state_e      state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    logic [3:0]  idx;
    logic        illegal;
    logic [15:0] pready_ext, pslverr_ext, psel_full;
    logic [31:0] sel_rdata;
    logic        sel_ready, sel_err, wd_fire, set_tmo;

    // Upper bits are region-decoded upstream; low bits belong to the slave.
    logic unused_addr;
    assign unused_addr = ^{paddr_i[31:SLV_ADDR_WIDTH+4], paddr_i[SLV_ADDR_WIDTH-1:0]};

    assign idx         = paddr_i[SLV_ADDR_WIDTH+3:SLV_ADDR_WIDTH];
    assign illegal     = ({1'b0, idx} >= NumSlvW) || (SEC_MASK[idx] && !pprot_i);
    assign pready_ext  = 16'(pready_s_i);
    assign pslverr_ext = 16'(pslverr_s_i);
    assign sel_ready   = pready_ext[slot_q];
    assign sel_err     = pslverr_ext[slot_q];
    assign wd_fire     = TimeoutEn && (cnt_q == TimeoutW) && psel_i && penable_i && !sel_ready;
    assign psel_o      = psel_full[NUM_SLV-1:0];
    assign timeout_o   = timeout_q;

    // Select the read data of the registered slot.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slot_q == 4'(i)) begin
                sel_rdata = prdata_s_i[32*i +: 32];
            end
        end
    end

    // Next-state, wait counter, watchdog and bridge-side response.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        set_tmo   = 1'b0;
        psel_full = '0;
        penable_o = 1'b0;
        pready_o  = 1'b1;
        pslverr_o = 1'b0;
        prdata_o  = '0;

        unique case (state_q)
            StIdle: begin
                if (psel_i && !penable_i) begin
                    if (illegal) begin
                        state_d = StErr;
                    end else begin
                        psel_full[idx] = 1'b1;
                        slot_d         = idx;
                        cnt_d          = '0;
                        state_d        = StFwd;
                    end
                end
            end
            StFwd: begin
                if (wd_fire) begin
                    // Abort: slave is cut off and the bridge sees an error completion.
                    pslverr_o = 1'b1;
                    set_tmo   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    psel_full[slot_q] = psel_i;
                    penable_o         = penable_i;
                    prdata_o          = sel_rdata;
                    pready_o          = sel_ready;
                    pslverr_o         = sel_err;
                    if (!psel_i) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (penable_i) begin
                        if (sel_ready) begin
                            state_d = StIdle;
                        end else if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
            end
            StErr: begin
                if (!psel_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (penable_i) begin
                    pslverr_o = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Set wins over clear.
        timeout_d = set_tmo ? 1'b1 : (timeout_clr_i ? 1'b0 : timeout_q);

        // Combinational IDLE decode must not leak a select while reset is held.
        if (!PRESETn) begin
            psel_full = '0;
            penable_o = 1'b0;
            pready_o  = 1'b1;
            pslverr_o = 1'b0;
            prdata_o  = '0;
        end
    end

    // State, slot, counter and sticky flag registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            slot_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_m3ds_apb_slave_mux_sec.sv
// Self-checking bench for m3ds_apb_slave_mux_sec: directed scenarios plus random transfers
// checked against a transaction-level model of decode, security, waits and watchdog.
module tb_m3ds_apb_slave_mux_sec;

    localparam int          NSLV = 4;
    localparam int          AW   = 12;
    localparam int          TMO  = 4;
    localparam logic [15:0] SECM = 16'h0002;

    logic                 PCLK = 1'b0;
    logic                 PRESETn;
    logic                 psel_i, penable_i, pprot_i, timeout_clr_i;
    logic [31:0]          paddr_i;
    logic [32*NSLV-1:0]   prdata_s_i;
    logic [NSLV-1:0]      pready_s_i, pslverr_s_i;
    logic [NSLV-1:0]      psel_o;
    logic                 penable_o, pready_o, pslverr_o, timeout_o;
    logic [31:0]          prdata_o;

    int   checks = 0;
    int   errors = 0;
    logic exp_tmo = 1'b0;

    m3ds_apb_slave_mux_sec #(
        .NUM_SLV        (NSLV),
        .SLV_ADDR_WIDTH (AW),
        .SEC_MASK       (SECM),
        .TIMEOUT        (TMO)
    ) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .psel_i        (psel_i),
        .paddr_i       (paddr_i),
        .penable_i     (penable_i),
        .pprot_i       (pprot_i),
        .prdata_s_i    (prdata_s_i),
        .pready_s_i    (pready_s_i),
        .pslverr_s_i   (pslverr_s_i),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .prdata_o      (prdata_o),
        .pready_o      (pready_o),
        .pslverr_o     (pslverr_o),
        .timeout_o     (timeout_o),
        .timeout_clr_i (timeout_clr_i)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Selected slot gets the given response; every other slot gets noise.
    task automatic drive_slaves(input int sel, input logic rdy, input logic err,
                                input logic [31:0] data);
        for (int i = 0; i < NSLV; i++) begin
            if (i == sel) begin
                pready_s_i[i]           = rdy;
                pslverr_s_i[i]          = err;
                prdata_s_i[32*i +: 32]  = data;
            end else begin
                pready_s_i[i]           = 1'($urandom);
                pslverr_s_i[i]          = 1'($urandom);
                prdata_s_i[32*i +: 32]  = $urandom;
            end
        end
    endtask

    // One idle cycle (psel_i low) with optional flag clear.
    task automatic idle(input bit clr);
        psel_i        = 1'b0;
        penable_i     = 1'b0;
        timeout_clr_i = clr;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        @(negedge PCLK);
        chk("idle_psel", 32'(psel_o), 32'h0);
        chk("idle_penable", 32'(penable_o), 32'h0);
        chk("idle_pready", 32'(pready_o), 32'h1);
        chk("idle_pslverr", 32'(pslverr_o), 32'h0);
        chk("idle_prdata", prdata_o, 32'h0);
        chk("idle_timeout", 32'(timeout_o), 32'(exp_tmo));
        @(posedge PCLK); #1;
        if (clr) exp_tmo = 1'b0;
        timeout_clr_i = 1'b0;
    endtask

    // Full SETUP+ACCESS transfer; selected slave inserts 'waits' wait states.
    task automatic xfer(input logic [31:0] addr, input logic prot, input int waits,
                        input logic serr, input logic [31:0] data, input bit clr, input bit b2b);
        int         idx   = int'(addr[AW+3:AW]);
        bit         legal = (idx < NSLV) && !(SECM[idx] && !prot);
        bit         abort = legal && (TMO != 0) && (waits > TMO);
        int         ncyc  = !legal ? 1 : (abort ? TMO + 1 : waits + 1);
        logic [3:0] onehot = legal ? 4'(1 << idx) : 4'h0;
        psel_i        = 1'b1;
        penable_i     = 1'b0;
        paddr_i       = addr;
        pprot_i       = prot;
        timeout_clr_i = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        @(negedge PCLK);
        chk("setup_psel", 32'(psel_o), 32'(onehot));
        chk("setup_penable", 32'(penable_o), 32'h0);
        chk("setup_pready", 32'(pready_o), 32'h1);
        chk("setup_timeout", 32'(timeout_o), 32'(exp_tmo));
        @(posedge PCLK); #1;
        penable_i = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            bit done = (c == ncyc);
            drive_slaves(legal ? idx : -1, 1'(c > waits), serr && (c > waits), data);
            timeout_clr_i = done ? clr : 1'b0;
            @(negedge PCLK);
            chk("access_pready", 32'(pready_o), 32'(done));
            if (!done) begin
                chk("wait_psel", 32'(psel_o), 32'(onehot));
                chk("wait_penable", 32'(penable_o), 32'h1);
            end else begin
                chk("done_psel", 32'(psel_o), (legal && !abort) ? 32'(onehot) : 32'h0);
                chk("done_penable", 32'(penable_o), 32'(legal && !abort));
                chk("done_pslverr", 32'(pslverr_o), 32'(!legal || abort || serr));
                chk("done_prdata", prdata_o, (legal && !abort) ? data : 32'h0);
            end
            @(posedge PCLK); #1;
        end
        timeout_clr_i = 1'b0;
        if (abort) exp_tmo = 1'b1;
        else if (clr) exp_tmo = 1'b0;
        if (!b2b) begin
            psel_i    = 1'b0;
            penable_i = 1'b0;
        end
    endtask

    initial begin
        PRESETn       = 1'b0;
        psel_i        = 1'b0;
        penable_i     = 1'b0;
        pprot_i       = 1'b0;
        paddr_i       = '0;
        timeout_clr_i = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rst_psel", 32'(psel_o), 32'h0);
        chk("rst_pready", 32'(pready_o), 32'h1);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        @(posedge PCLK); @(posedge PCLK); #1;
        PRESETn = 1'b1;
        idle(1'b0);

        // Slot 2 zero-wait read.
        xfer(32'h0000_2010, 1'b0, 0, 1'b0, 32'hA5A5_0002, 1'b0, 1'b0);
        idle(1'b0);
        // Secure slot 1: blocked non-secure, then forwarded secure.
        xfer(32'h0000_1000, 1'b0, 0, 1'b0, 32'h1111_0001, 1'b0, 1'b0);
        xfer(32'h0000_1000, 1'b1, 1, 1'b0, 32'h1111_0001, 1'b0, 1'b0);
        // Unmapped slot 5.
        xfer(32'h0000_5000, 1'b1, 0, 1'b0, 32'h5555_0005, 1'b0, 1'b0);
        // Hung slot 0: abort on ACCESS cycle TMO+1, then clear the flag.
        xfer(32'h0000_0000, 1'b0, 20, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        // Slot 3 with waits just under the limit plus slave error, back-to-back into slot 0.
        xfer(32'h0000_3004, 1'b0, 3, 1'b1, 32'h3333_0003, 1'b0, 1'b1);
        xfer(32'h0000_0008, 1'b0, 0, 1'b0, 32'h0000_CAFE, 1'b0, 1'b0);
        // Waits exactly TMO completes normally.
        xfer(32'h0000_2000, 1'b0, TMO, 1'b0, 32'h2222_2222, 1'b0, 1'b0);
        // Abort with a same-cycle clear: set wins.
        xfer(32'h0000_3000, 1'b0, 9, 1'b0, 32'h3333_3333, 1'b1, 1'b0);
        idle(1'b1);

        // Abandon a waiting transfer, then a normal one.
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h0000_0000; pprot_i = 1'b0;
        @(posedge PCLK); #1;
        penable_i = 1'b1;
        drive_slaves(0, 1'b0, 1'b0, 32'h0);
        repeat (3) begin @(posedge PCLK); #1; end
        psel_i = 1'b0; penable_i = 1'b0;
        @(posedge PCLK); #1;
        idle(1'b0);
        xfer(32'h0000_0000, 1'b0, TMO, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Reset during a slot-1 wait state, after setting the sticky flag.
        xfer(32'h0000_2000, 1'b0, 8, 1'b0, 32'h0, 1'b0, 1'b0);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h0000_1000; pprot_i = 1'b1;
        @(posedge PCLK); #1;
        penable_i = 1'b1;
        drive_slaves(1, 1'b0, 1'b0, 32'h1234_5678);
        @(posedge PCLK); #1;
        @(negedge PCLK); #2;
        PRESETn = 1'b0;
        exp_tmo = 1'b0;
        #1;
        chk("rst_mid_psel", 32'(psel_o), 32'h0);
        chk("rst_mid_penable", 32'(penable_o), 32'h0);
        chk("rst_mid_pready", 32'(pready_o), 32'h1);
        chk("rst_mid_pslverr", 32'(pslverr_o), 32'h0);
        chk("rst_mid_prdata", prdata_o, 32'h0);
        chk("rst_mid_timeout", 32'(timeout_o), 32'h0);
        penable_i = 1'b0;
        paddr_i   = 32'h0000_0000;
        #1;
        chk("rst_setup_psel", 32'(psel_o), 32'h0);
        @(posedge PCLK); #1;
        psel_i  = 1'b0;
        PRESETn = 1'b1;
        idle(1'b0);
        xfer(32'h0000_0010, 1'b0, 1, 1'b0, 32'h600D_0000, 1'b0, 1'b0);
        idle(1'b0);

        // Random transfers against the model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            bit          b2b;
            a        = $urandom;
            a[15:12] = 4'($urandom_range(0, 7));
            b2b      = 1'($urandom_range(0, 1));
            xfer(a, 1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom,
                 $urandom_range(0, 3) == 0, b2b);
            if (!b2b) idle($urandom_range(0, 3) == 0);
        end
        idle(1'b1);
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
